fp_regfile_wb: RTL
==================

Name: fp_regfile_wb

Overview:
- 32 x 32-bit floating-point register file ($f0-$f31) for the MIPS FPU coprocessor.
- Directly upstream and downstream of the combinational FP ALU (coprocessor1):
  - two read ports drive its data1/data2 operands;
  - its floatRes result is captured through a one-entry writeback register, then committed to the array.
- Also provides the integer-side mtc1/mfc1 path and the FP condition flag (FCC) used by bc1t/bc1f.

Parameters:
- NREG, 32, number of FP registers (address width is log2(NREG) = 5).
- WIDTH, 32, register width in bits (IEEE-754 single).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rs_addr  in  5  read address for operand A
- rt_addr  in  5  read address for operand B
- data1  out  32  operand A to FP ALU
- data2  out  32  operand B to FP ALU
- wr_en  in  1  FP ALU result write request this cycle
- wr_addr  in  5  destination register for floatRes
- floatRes  in  32  FP ALU result
- mtc1_en  in  1  integer-to-FP move request
- mtc1_addr  in  5  mtc1 destination register
- mtc1_data  in  32  mtc1 source value
- mtc1_ready  out  1  mtc1 accepted this cycle
- mfc1_addr  in  5  FP-to-integer read address
- mfc1_data  out  32  FP-to-integer read data
- fcc_wr  in  1  compare result write enable
- fcc_in  in  1  compare result
- fcc  out  1  condition flag
- wb_busy  out  1  writeback register holds an uncommitted write

Behaviour:
- Reset (synchronous, active-high):
  - all 32 registers become 0;
  - wb_valid, wb_addr and wb_data are cleared; fcc becomes 0.
  - Reset asserted in the same cycle as wr_en or mtc1_en: the write is discarded.
  - A pending writeback is discarded, never committed.
- Writeback pipeline:
  - Edge N, accepted request: wb_valid <= 1, wb_addr and wb_data are captured.
  - Edge N+1: the array is written at wb_addr.
  - If no new request is accepted at edge N+1, wb_valid <= 0.
  - A new request at edge N+1 refills the wb register while the old entry commits; throughput is one write per cycle.
- Write arbitration:
  - mtc1_ready = ~wr_en (combinational); the FP ALU result has priority.
  - With wr_en=1 and mtc1_en=1, mtc1 is not accepted and must be held by the requester.
- Reads: data1, data2 and mfc1_data are combinational from the array, with bypass from the wb register when wb_valid is set and wb_addr matches the read address.
- No bypass from the wr_en/floatRes inputs. This avoids a combinational loop data1 -> FP ALU -> floatRes -> data1.
  - A read in the same cycle as a write request to the same address returns the old value.
  - Result visible in cycle N+1 via bypass, and from cycle N+2 out of the array.
- Same-address corner case: wb entry pending to addr A and a new write to A at the same edge.
  - The array takes the old value.
  - The wb register takes the new value.
  - Reads return the new value.
- $f0 is writable (not hardwired zero).
- FCC: when fcc_wr is set, fcc <= fcc_in at the edge. Reads are registered only, with no bypass; the compare-to-branch latency of one cycle is accepted.
- wb_busy = wb_valid.

Decomposition:
- Shared package/header `fpu_defs`:
  - FP_WIDTH = 32;
  - FP_REG_ADDR_W = 5;
  - FloatALUop encodings, with ADD = 3'd0;
  - IEEE field positions: sign bit 31, exponent 30:23, mantissa 22:0.
- One natural sub-module, fp_wb_stage: holds wb_valid/wb_addr/wb_data and implements the arbitration mux and mtc1_ready.
- The top level holds the array, the bypass compare and the FCC flop.

Test Plan:
- Reset, then read all 32 addresses -> every data1/data2/mfc1_data is 32'h00000000; fcc=0; wb_busy=0.
- Write-through path:
  - Stimulus: mtc1 $f1=32'h42C80000, next cycle $f2=32'h41C80000; rs=1, rt=2; FP ALU add (op 0) feeds floatRes; wr_en to $f3.
  - Required: cycle N+1, rs=3 returns 32'h42fa0000 via bypass with wb_busy=1; cycle N+2 returns 32'h42fa0000 with wb_busy=0.
- Same-cycle hazard: wr_en to $f4 with value 32'h40000000 while rs_addr=4 -> data1 is still the old value (0) that cycle, and 32'h40000000 the next.
- Arbitration: wr_en=1 ($f5=32'h3f8ccccd) and mtc1_en=1 ($f5=32'hc5aff000) in the same cycle.
  - Required: mtc1_ready=0; $f5 reads 32'h3f8ccccd.
  - Holding mtc1 one more cycle with wr_en=0 gives mtc1_ready=1 and $f5 = 32'hc5aff000 two cycles later.
- Back-to-back to the same address: writes $f6=32'h402ccccd then $f6=32'h44b36333 on consecutive edges -> reads of $f6 give 32'h402ccccd, then 32'h44b36333 thereafter; never a stale 0.
- Reset mid-operation:
  - Stimulus: wr_en to $f7=32'h017FFFFF, then reset asserted the following cycle.
  - Required: $f7 reads 0 after reset and wb_busy=0.
  - fcc_wr with fcc_in=1 sets fcc=1 one cycle later; reset clears it.

Source files
------------

// File: rtl/fpu_defs_pkg.sv
// rtl/fpu_defs_pkg.sv - shared FPU definitions: widths, ALU op codes, IEEE-754 field positions
package fpu_defs;

  localparam int FP_WIDTH      = 32;
  localparam int FP_REG_ADDR_W = 5;

  // FP ALU operation encodings (coprocessor1)
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    ABS = 3'd4,
    NEG = 3'd5,
    MOV = 3'd6,
    CMP = 3'd7
  } FloatALUop;

  // IEEE-754 single-precision field positions
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_MSB  = 30;
  localparam int FP_EXP_LSB  = 23;
  localparam int FP_MAN_MSB  = 22;
  localparam int FP_MAN_LSB  = 0;

  typedef logic [FP_WIDTH-1:0] fpWord;

  function automatic logic fpSign(input fpWord w);
    return w[FP_SIGN_BIT];
  endfunction

endpackage

// File: rtl/fp_regfile_wb_wb_stage.sv
// rtl/fp_regfile_wb_wb_stage.sv - one-entry writeback register with FP ALU / mtc1 arbitration
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/floatRes FP ALU result write request (highest priority)
//   mtc1_en/addr/data      integer-to-FP move request
//   mtc1_ready             mtc1 accepted this cycle (= ~wr_en)
//   wbValid/wbAddr/wbData  pending writeback entry, committed to the array next edge
module fp_wb_stage
  import fpu_defs::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int AW    = FP_REG_ADDR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] floatRes,
  input  logic             mtc1_en,
  input  logic [AW-1:0]    mtc1_addr,
  input  logic [WIDTH-1:0] mtc1_data,
  output logic             mtc1_ready,
  output logic             wbValid,
  output logic [AW-1:0]    wbAddr,
  output logic [WIDTH-1:0] wbData
);

  logic             reqValid;
  logic [AW-1:0]    reqAddr;
  logic [WIDTH-1:0] reqData;

  // FP ALU result wins; a blocked mtc1 is held by its requester.
  assign mtc1_ready = ~wr_en;

  always_comb begin
    reqValid = wr_en | mtc1_en;
    reqAddr  = wr_en ? wr_addr  : mtc1_addr;
    reqData  = wr_en ? floatRes : mtc1_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbValid <= 1'b0;
      wbAddr  <= '0;
      wbData  <= '0;
    end else begin
      wbValid <= reqValid;
      if (reqValid) begin
        wbAddr <= reqAddr;
        wbData <= reqData;
      end
    end
  end

endmodule

// File: rtl/fp_regfile_wb.sv
// rtl/fp_regfile_wb.sv - 32x32 FP register file with writeback register, bypass and FCC flag
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   rs_addr/rt_addr         operand read addresses -> data1/data2 (to FP ALU)
//   wr_en/wr_addr/floatRes  FP ALU result write request
//   mtc1_en/addr/data       integer-to-FP move; mtc1_ready = accepted this cycle
//   mfc1_addr -> mfc1_data  FP-to-integer read path
//   fcc_wr/fcc_in -> fcc    FP condition flag for bc1t/bc1f
//   wb_busy                 writeback register holds an uncommitted write
module fp_regfile_wb
  import fpu_defs::*;
#(
  parameter int NREG  = 32,
  parameter int WIDTH = FP_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  input  logic [$clog2(NREG)-1:0] rt_addr,
  output logic [WIDTH-1:0]        data1,
  output logic [WIDTH-1:0]        data2,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        floatRes,
  input  logic                    mtc1_en,
  input  logic [$clog2(NREG)-1:0] mtc1_addr,
  input  logic [WIDTH-1:0]        mtc1_data,
  output logic                    mtc1_ready,
  input  logic [$clog2(NREG)-1:0] mfc1_addr,
  output logic [WIDTH-1:0]        mfc1_data,
  input  logic                    fcc_wr,
  input  logic                    fcc_in,
  output logic                    fcc,
  output logic                    wb_busy
);

  localparam int AW = $clog2(NREG);

  logic [WIDTH-1:0] regs [NREG];
  logic             wbValid;
  logic [AW-1:0]    wbAddr;
  logic [WIDTH-1:0] wbData;

  fp_wb_stage #(.WIDTH(WIDTH), .AW(AW)) uWb (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .floatRes   (floatRes),
    .mtc1_en    (mtc1_en),
    .mtc1_addr  (mtc1_addr),
    .mtc1_data  (mtc1_data),
    .mtc1_ready (mtc1_ready),
    .wbValid    (wbValid),
    .wbAddr     (wbAddr),
    .wbData     (wbData)
  );

  assign wb_busy = wbValid;

  // Commit the pending entry; a refill at the same edge only touches the wb
  // register, so the array takes the older value and bypass serves the newer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wbValid) begin
      regs[wbAddr] <= wbData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       fcc <= 1'b0;
    else if (fcc_wr) fcc <= fcc_in;
  end

  // Bypass only from the wb register; bypassing floatRes would close a
  // combinational loop through the FP ALU.
  always_comb begin
    data1     = (wbValid && wbAddr == rs_addr)   ? wbData : regs[rs_addr];
    data2     = (wbValid && wbAddr == rt_addr)   ? wbData : regs[rt_addr];
    mfc1_data = (wbValid && wbAddr == mfc1_addr) ? wbData : regs[mfc1_addr];
  end

endmodule
